// File: rtl/seq_div16.sv
// Sequential unsigned divider by repeated subtraction.
// Dividend and divisor arrive on data_in in consecutive cycles; done pulses once per result.
module seq_div16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADB,
      S_CHECK,
      S_SUB,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             dbz_q, dbz_d;
   logic             r_ge_d;

   // The compare guards the subtractor, so R - D never underflows.
   assign r_ge_d = (r_q >= d_q);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: a default assignment at the top of each combinational block keeps
   // every path assigned, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOADB;
         S_LOADB: state_d = S_CHECK;
         S_CHECK: state_d = (d_q == '0) ? S_DONE : S_SUB;
         S_SUB:   if (!r_ge_d) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_LOADB) || (state_q == S_CHECK) || (state_q == S_SUB);
      done = (state_q == S_DONE);
   end

   always_comb begin
      r_d   = r_q;
      d_d   = d_q;
      q_d   = q_q;
      dbz_d = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d   = data_in;
               q_d   = '0;
               dbz_d = 1'b0;
            end
         end
         S_LOADB: d_d = data_in;
         S_CHECK: begin
            if (d_q == '0) begin
               q_d   = '1;
               dbz_d = 1'b1;
            end
         end
         S_SUB: begin
            if (r_ge_d) begin
               r_d = r_q - d_q;
               q_d = q_q + WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: the datapath registers are cleared by the asynchronous reset so the
   // result outputs read 0 immediately, even when reset lands mid-division.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         d_q   <= '0;
         q_q   <= '0;
         dbz_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         d_q   <= d_d;
         q_q   <= q_d;
         dbz_q <= dbz_d;
      end
   end

   assign quotient    = q_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_div16.md
# seq_div16

Sequential 16-bit unsigned divider built from repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier. Operands arrive over a shared 16-bit `data_in` bus on two consecutive cycles, in the same style as the multiplier: dividend first, then divisor. An internal controller FSM sequences a datapath of a remainder register, a divisor register, a quotient counter, a subtractor and a comparator, and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width. All values below assume 16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request. Sampled only in IDLE; `data_in` carries the dividend in the same cycle.
- `data_in`  in  16  operand bus. Dividend on the `start` cycle, divisor on the following cycle.
- `quotient`  out  16  quotient. Reset value 0.
- `remainder`  out  16  remainder. Reset value 0.
- `busy`  out  1  high in LOADB, CHECK and SUB. Reset value 0.
- `done`  out  1  one-cycle completion pulse. Reset value 0.
- `div_by_zero`  out  1  error flag. Reset value 0.

## Operation
- Registers:
  - R: remainder / working dividend.
  - D: divisor.
  - Q: quotient counter.
  - `quotient` and `remainder` are Q and R driven directly.
- States: IDLE, LOADB, CHECK, SUB, DONE.
- IDLE:
  - On `start`=1: R <= `data_in`, Q <= 0, `div_by_zero` <= 0, go to LOADB.
  - Otherwise hold all registers.
- LOADB: D <= `data_in`. Go to CHECK unconditionally; `start` is ignored.
- CHECK:
  - If D==0: Q <= 16'hFFFF, R unchanged, `div_by_zero` <= 1, go to DONE.
  - Otherwise go to SUB.
- SUB:
  - If R >= D (unsigned): R <= R - D, Q <= Q + 1, stay in SUB.
  - Otherwise go to DONE, with R and Q unchanged.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Arithmetic:
  - The subtraction is 16-bit unsigned and never underflows, because it is guarded by the R >= D compare.
  - Q never wraps, since Q ≤ dividend ≤ 65535.
- Output validity:
  - Q, R and `div_by_zero` are valid in the DONE cycle.
  - They hold until the next accepted `start`.
  - While `busy`=1 they show intermediate values and must not be sampled.
- `start` outside IDLE, including in DONE, is ignored and has no effect.
- Reset (`rst_n`=0, asynchronous, in any state, including mid-SUB):
  - State goes to IDLE; R, D, Q are cleared; all outputs go to 0 immediately.
  - Operation resumes on the first `start` after `rst_n` rises.

## Timing
- Cycle numbering: the `start` cycle is cycle 0. N = floor(dividend/divisor).
- Cycle 1: in LOADB, divisor sampled. `busy` first reads 1 in cycle 1.
- Cycle 2: in CHECK.
- Nonzero divisor:
  - Cycles 3 .. 2+N: one subtraction each.
  - Cycle 3+N: SUB sees R<D.
  - Cycle 4+N: DONE, `done`=1. Total latency 4+N cycles.
- Divisor 0: cycle 3 is DONE. Latency 3.
- Worst case: 65535/1 finishes at cycle 65539.
- `busy` is 0 in the DONE cycle.
- Back-to-back: `start` is accepted no earlier than the cycle after `done`, i.e. the IDLE cycle.
- There are no combinational paths from inputs to outputs; all outputs are registered or decoded from state.

## Test plan
- 100 / 7:
  - Required: Q=14, R=2, `done` pulse exactly at cycle 18.
  - `busy` high in cycles 1–17.
  - `div_by_zero`=0.
- 5 / 9: Q=0, R=5, `done` at cycle 4; SUB is entered once and exits with no subtraction.
- 1234 / 0:
  - Required: `div_by_zero`=1, Q=16'hFFFF, R=1234, `done` at cycle 3.
  - The flag is held in IDLE and cleared by the next accepted `start`.
- 65535 / 1: Q=65535, R=0, `done` at cycle 65539, no wrap on Q.
- `start` re-asserted in cycles 1–10 of a 1000/3 run, then `rst_n` pulsed low at cycle 20:
  - The re-asserted `start` has no effect.
  - On reset, outputs go to 0 immediately and the state is IDLE.
  - A fresh 1000/3 run then yields Q=333, R=1, `done` at cycle 337.
- 42 / 0 then 42 / 6, with the second `start` in the cycle after the first `done`:
  - The second `start` is accepted.
  - Second run: `div_by_zero` cleared, Q=7, R=0, `done` 11 cycles after the second `start`.
